// File: rtl/norz_cycle_sequencer.sv
// Machine-cycle sequencer for the instruction decoder tree: owns the phase
// timer (XPT), opcode latch (ITABLE) and operand latches (OP/OPold).
module norz_cycle_sequencer #(
    parameter logic [3:0] XPT_MAX = 4'd15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mem_ready,
    input  logic [7:0] data_in,
    input  logic       hold,
    input  logic       P2_Set_CM1,
    input  logic       P2_Set_CMR,
    input  logic       P2_Set_CMA,
    input  logic       PR_Reset_XPT,
    input  logic       P2_Reset_ITABLE,
    output logic       mem_req,
    output logic       dec_enable,
    output logic [3:0] XPT,
    output logic [3:0] notXPT,
    output logic [7:0] ITABLE,
    output logic [7:0] notITABLE,
    output logic [7:0] OP,
    output logic [7:0] OPold,
    output logic       CM1,
    output logic       CMR,
    output logic       CMA,
    output logic       fault
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_READ  = 2'd2,
        S_ALU   = 2'd3
    } state_t;

    localparam logic [2:0] CLS_CM1 = 3'b001;
    localparam logic [2:0] CLS_CMR = 3'b010;
    localparam logic [2:0] CLS_CMA = 3'b100;

    state_t     state_q, state_d;
    logic [3:0] xpt_q, xpt_d;
    logic [7:0] itable_q, itable_d;
    logic [7:0] op_q, op_d;
    logic [7:0] opold_q, opold_d;
    logic [2:0] cls_q, cls_d;
    logic       fault_q, fault_d;

    logic       set_any;
    logic       set_multi;

    assign set_any   = P2_Set_CM1 | P2_Set_CMR | P2_Set_CMA;
    assign set_multi = (P2_Set_CM1 & P2_Set_CMR) | (P2_Set_CM1 & P2_Set_CMA) |
                       (P2_Set_CMR & P2_Set_CMA);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_FETCH;
            xpt_q    <= 4'd0;
            itable_q <= 8'h00;
            op_q     <= 8'h00;
            opold_q  <= 8'h00;
            cls_q    <= CLS_CM1;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            xpt_q    <= xpt_d;
            itable_q <= itable_d;
            op_q     <= op_d;
            opold_q  <= opold_d;
            cls_q    <= cls_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        xpt_d    = xpt_q;
        itable_d = itable_q;
        op_d     = op_q;
        opold_d  = opold_q;
        cls_d    = cls_q;
        fault_d  = fault_q;

        unique case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    itable_d = data_in;
                    xpt_d    = 4'd0;
                    state_d  = S_EXEC;
                end
            end
            S_READ: begin
                if (mem_ready) begin
                    opold_d = op_q;
                    op_d    = data_in;
                    state_d = S_EXEC;
                end
            end
            S_ALU: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (!hold) begin
                    if (set_multi) begin
                        fault_d = 1'b1;
                    end
                    if (P2_Reset_ITABLE) begin
                        itable_d = 8'h00;
                    end
                    // XPT saturates at XPT_MAX so it can never wrap to zero
                    if (PR_Reset_XPT || P2_Set_CM1) begin
                        xpt_d = 4'd0;
                    end else if (xpt_q != XPT_MAX) begin
                        xpt_d = xpt_q + 4'd1;
                    end

                    if (P2_Set_CM1) begin
                        state_d = S_FETCH;
                        cls_d   = CLS_CM1;
                    end else if (P2_Set_CMR) begin
                        state_d = S_READ;
                        cls_d   = CLS_CMR;
                    end else if (P2_Set_CMA) begin
                        state_d = S_ALU;
                        cls_d   = CLS_CMA;
                    end else if ((xpt_q == XPT_MAX) && !PR_Reset_XPT) begin
                        // Missing end-of-instruction: abandon and refetch
                        fault_d  = 1'b1;
                        itable_d = 8'h00;
                        state_d  = S_FETCH;
                        cls_d    = CLS_CM1;
                    end
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign mem_req    = !reset && ((state_q == S_FETCH) || (state_q == S_READ));
    assign dec_enable = !reset && (state_q == S_EXEC);
    assign XPT        = xpt_q;
    assign notXPT     = ~xpt_q;
    assign ITABLE     = itable_q;
    assign notITABLE  = ~itable_q;
    assign OP         = op_q;
    assign OPold      = opold_q;
    assign CM1        = cls_q[0];
    assign CMR        = cls_q[1];
    assign CMA        = cls_q[2];
    assign fault      = fault_q;

endmodule
